// File: rtl/lut_mult_arbiter.sv
// lut_mult_arbiter: round-robin arbiter feeding one shared 3-stage signed 4x4 LUT multiplier.
// Defining LMA_STATS_EN adds the op_count completed-operation counter port.
module lut_mult_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic [IDW-1:0]    res_id
`ifdef LMA_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);

    // Magnitude product table indexed by mag_a*9 + mag_b, magnitudes 0..8.
    function automatic logic [80:0][6:0] build_lut();
        logic [80:0][6:0] t;
        t = '0;
        for (int x = 0; x < 9; x++) begin
            for (int y = 0; y < 9; y++) begin
                t[7'(x * 9 + y)] = 7'(x * y);
            end
        end
        return t;
    endfunction

    localparam logic [80:0][6:0] LUT = build_lut();

    // Returns {sign, magnitude}; -8 codes to magnitude 4'b1000 without wrapping.
    function automatic logic [4:0] code_operand(input logic [3:0] x);
        return {x[3], (x ^ {4{x[3]}}) + {3'b000, x[3]}};
    endfunction

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [3:0]     gnt_a, gnt_b;
    int             best, off;

    logic           s0_v, s1_v, s2_v;
    logic [3:0]     s0_a, s0_b;
    logic [IDW-1:0] s0_id, s1_id;
    logic [4:0]     s1_a, s1_b;
    logic           s0_load, s1_load, s2_load, accept;
    logic [6:0]     lut_idx;
    logic [6:0]     prod_mag;
    logic [7:0]     prod;

    // Search order starts at ptr+1: off is the distance from that starting point.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        gnt_a   = '0;
        gnt_b   = '0;
        best    = NREQ;
        off     = 0;
        for (int j = 0; j < NREQ; j++) begin
            off = (j + NREQ - 1 - int'(ptr)) % NREQ;
            if (req_valid[j] && off < best) begin
                best    = off;
                gnt_any = 1'b1;
                gnt_id  = IDW'(j);
                gnt_a   = req_a[4*j +: 4];
                gnt_b   = req_b[4*j +: 4];
            end
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a stage loads when empty or when its contents move on in the same cycle.
    assign s2_load   = !s2_v || res_ready;
    assign s1_load   = !s1_v || s2_load;
    assign s0_load   = !s0_v || s1_load;
    assign accept    = rst_n && gnt_any && s0_load && !flush;
    assign res_valid = s2_v;

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = accept && (gnt_id == IDW'(j));
        end
    end

    always_comb begin
        lut_idx  = {3'b000, s1_a[3:0]} * 7'd9 + {3'b000, s1_b[3:0]};
        prod_mag = LUT[lut_idx];
        prod     = (s1_a[4] ^ s1_b[4]) ? (8'd0 - {1'b0, prod_mag}) : {1'b0, prod_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDW'(NREQ - 1);
            s0_v     <= 1'b0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            res_data <= '0;
            res_id   <= '0;
        end else begin
            if (accept) begin
                ptr <= gnt_id;
            end
            if (flush) begin
                s0_v <= 1'b0;
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (s0_load) s0_v <= accept;
                if (s1_load) s1_v <= s0_v;
                if (s2_load) s2_v <= s1_v;
            end
            if (s0_load && accept) begin
                s0_a  <= gnt_a;
                s0_b  <= gnt_b;
                s0_id <= gnt_id;
            end
            if (s1_load && s0_v) begin
                s1_a  <= code_operand(s0_a);
                s1_b  <= code_operand(s0_b);
                s1_id <= s0_id;
            end
            if (s2_load && s1_v) begin
                res_data <= prod;
                res_id   <= s1_id;
            end
        end
    end

`ifdef LMA_STATS_EN
    // Only rst_n clears the counter; a result taken during a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_v && res_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lut_mult_arbiter.sv
// Directed bench for lut_mult_arbiter: reset, corners, round robin, backpressure, flush, streaming.
// Build with LMA_STATS_EN defined to also check op_count.
module tb_lut_mult_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a = '0;
    logic [4*NREQ-1:0] req_b = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [7:0]        res_data;
    logic [IDW-1:0]    res_id;
`ifdef LMA_STATS_EN
    logic [15:0]       op_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    lut_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_id(res_id)
`ifdef LMA_STATS_EN
        ,
        .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa, sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        return 8'(sa * sb);
    endfunction

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[4*id +: 4] = a;
        req_b[4*id +: 4] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        int lat;
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data got %h want 00", res_data); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got %h want 0", res_id); end
`ifdef LMA_STATS_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 2'b01;
        set_req(0, 4'd3, 4'hE);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL first_accept got %b want 01", req_ready); end
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (res_valid) lat = c;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL first_latency got %0d want 3", lat); end
        checks++; if (res_data !== 8'hFA) begin errors++; $display("FAIL first_data got %h want fa", res_data); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL first_id got %h want 0", res_id); end
    endtask

    task automatic test_corner();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [7:0] ve [3];
        int lat;
        va[0] = 4'h8; vb[0] = 4'h8; ve[0] = 8'h40;
        va[1] = 4'h8; vb[1] = 4'h7; ve[1] = 8'hC8;
        va[2] = 4'h0; vb[2] = 4'hB; ve[2] = 8'h00;
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            req_valid = 2'b01;
            set_req(0, va[v], vb[v]);
            lat = 0;
            for (int c = 1; c <= 10 && lat == 0; c++) begin
                @(negedge clk);
                req_valid = '0;
                #1;
                if (res_valid) lat = c;
            end
            checks++; if (lat !== 3) begin errors++; $display("FAIL corner%0d_latency got %0d want 3", v, lat); end
            checks++; if (res_data !== ve[v]) begin errors++; $display("FAIL corner%0d_data got %h want %h", v, res_data, ve[v]); end
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] exp;
        apply_reset();
        set_req(0, 4'd1, 4'd2);
        set_req(1, 4'hD, 4'd4);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            req_valid = (n < 4) ? 2'b11 : 2'b00;
            #1;
            if (res_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_unexpected got id %h data %h want none", res_id, res_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({res_id, res_data} !== exp) begin errors++; $display("FAIL rr_result got %h want %h", {res_id, res_data}, exp); end
                end
            end
            if (n < 4) begin
                checks++;
                if (req_ready !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_grant%0d got %b want %b", n, req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
                end
                exp_q.push_back((n % 2 == 0) ? {1'b0, mul4(4'd1, 4'd2)} : {1'b1, mul4(4'hD, 4'd4)});
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [3:0] oa [4];
        logic [3:0] ob [4];
        logic [8:0] exp;
        int k, rcv;
        oa[0] = 4'd2; ob[0] = 4'd3;
        oa[1] = 4'hC; ob[1] = 4'd5;
        oa[2] = 4'd7; ob[2] = 4'h9;
        oa[3] = 4'hF; ob[3] = 4'hF;
        exp_q.delete();
        k = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            res_ready = 1'b0;
            req_valid = 2'b01;
            set_req(0, oa[k], ob[k]);
            #1;
            checks++;
            if (req_ready !== ((n < 3) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL bp_ready%0d got %b want %b", n, req_ready, (n < 3) ? 2'b01 : 2'b00);
            end
            if (n < 3) begin
                exp_q.push_back({1'b0, mul4(oa[k], ob[k])});
                k++;
            end else begin
                checks++;
                if (res_valid !== 1'b1 || {res_id, res_data} !== exp_q[0]) begin
                    errors++; $display("FAIL bp_hold%0d got v=%b %h want v=1 %h", n, res_valid, {res_id, res_data}, exp_q[0]);
                end
            end
        end
        rcv = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            res_ready = 1'b1;
            req_valid = '0;
            #1;
            if (res_valid) begin
                rcv++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_duplicate got %h want none", {res_id, res_data});
                end else begin
                    exp = exp_q.pop_front();
                    if ({res_id, res_data} !== exp) begin errors++; $display("FAIL bp_drain got %h want %h", {res_id, res_data}, exp); end
                end
            end
        end
        checks++; if (rcv != 3) begin errors++; $display("FAIL bp_count got %0d want 3", rcv); end
    endtask

    task automatic test_flush();
        int lat;
        logic early;
        res_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b01;
        set_req(0, 4'd5, 4'd3);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_acc_x got %b want 01", req_ready); end
        @(negedge clk);
        set_req(0, 4'hA, 4'd2);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_acc_y got %b want 01", req_ready); end
        @(negedge clk);
        flush = 1'b1;
        set_req(0, 4'h9, 4'hD);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_no_accept got %b want 00", req_ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got %b want 0", res_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_acc_z got %b want 01", req_ready); end
        lat = 0;
        early = 1'b0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (res_valid) lat = c;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL flush_next_latency got %0d want 3", lat); end
        checks++; if (res_data !== 8'h15) begin errors++; $display("FAIL flush_next_data got %h want 15", res_data); end
    endtask

    task automatic test_stream();
        logic [8:0] exp;
        logic [3:0] a, b;
        int sent, rcv, cyc, done_cyc;
        apply_reset();
        sent = 0; rcv = 0; cyc = 0; done_cyc = 0;
        while (rcv < 300 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            a = 4'(sent);
            b = 4'(sent * 7 + 3);
            if (sent < 300) begin
                req_valid = 2'b01;
                set_req(0, a, b);
            end else begin
                req_valid = '0;
            end
            #1;
            if (res_valid) begin
                rcv++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_unexpected got %h want none", {res_id, res_data});
                end else begin
                    exp = exp_q.pop_front();
                    if ({res_id, res_data} !== exp) begin errors++; $display("FAIL stream_data got %h want %h", {res_id, res_data}, exp); end
                end
            end
            if (req_ready[0]) begin
                exp_q.push_back({1'b0, mul4(a, b)});
                sent++;
                if (sent == 300) done_cyc = cyc;
            end
        end
        checks++; if (done_cyc != 300) begin errors++; $display("FAIL stream_throughput got %0d cycles want 300", done_cyc); end
        checks++; if (rcv != 300) begin errors++; $display("FAIL stream_count got %0d want 300", rcv); end
`ifdef LMA_STATS_EN
        @(negedge clk);
        checks++; if (op_count !== 16'd300) begin errors++; $display("FAIL op_count got %0d want 300", op_count); end
`endif
    endtask

    task automatic test_mid_reset();
        logic seen;
        res_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            req_valid = 2'b01;
            set_req(0, 4'(n + 1), 4'd2);
        end
        #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", res_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got %b want 0", res_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midrst_req_ready got %b want 00", req_ready); end
`ifdef LMA_STATS_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL midrst_op_count got %0d want 0", op_count); end
`endif
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_ghost got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_corner();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_stream();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
